// File: rtl/pwm_generator.sv
// Double-buffered PWM: duty is captured only when the period counter wraps,
// so upstream level changes never chop a pulse mid-period.
module pwm_generator #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] duty,
    output logic         out,
    output logic         period_done
);

    // Last count value of a period; the counter never reaches all-ones.
    localparam logic [N-1:0] MAX = {{(N-1){1'b1}}, 1'b0};

    logic [N-1:0] count_q, count_d;
    logic [N-1:0] duty_q,  duty_d;
    logic         done_q,  done_d;

    // NOTE: every next-state signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        duty_d  = duty_q;
        done_d  = 1'b0;
        if (ena) begin
            if (count_q == MAX) begin
                count_d = '0;
                duty_d  = duty;
                done_d  = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            duty_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            duty_q  <= duty_d;
            done_q  <= done_d;
        end
    end

    // Output decoded from registers only: no path from duty or ena.
    assign out         = (count_q < duty_q);
    assign period_done = done_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator (N=4): directed scenarios with literal
// expectations plus randomized traffic, all checked against a tick-count model.
module tb_pwm_generator;

    localparam int N = 4;
    localparam int P = (1 << N) - 1;   // enabled ticks per period

    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic [N-1:0] duty;
    logic         out;
    logic         period_done;

    int checks   = 0;
    int failures = 0;

    pwm_generator #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .duty        (duty),
        .out         (out),
        .period_done (period_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: period position is simply enabled ticks since reset modulo P;
    // the duty in force is whatever was on the input at the last wrap tick.
    int model_ticks = 0;
    int model_duty  = 0;
    bit model_done  = 1'b0;
    bit model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst === 1'b0) begin
            model_ticks = 0;
            model_duty  = 0;
            model_done  = 1'b0;
            model_valid = 1'b1;
        end else if (ena === 1'b1) begin
            if ((model_ticks % P) == P - 1) begin
                model_duty = int'(duty);
                model_done = 1'b1;
            end else begin
                model_done = 1'b0;
            end
            model_ticks++;
        end else begin
            model_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_out",  int'(out),         int'((model_ticks % P) < model_duty));
            check("model_done", int'(period_done), int'(model_done));
        end
    end

    task automatic step(input logic r, input logic e, input int d);
        rst  = r;
        ena  = e;
        duty = d[N-1:0];
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs n clocks (ena toggling 1/0 if gated) and counts high samples.
    task automatic run(input int n, input int d, input bit gated,
                       output int hi, output int dn);
        hi = 0;
        dn = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b1, gated ? ((i % 2) == 0) : 1'b1, d);
            hi += int'(out);
            dn += int'(period_done);
        end
    endtask

    int hi, dn, hi2, dn2, hi3, dn3;

    initial begin
        rst  = 1'b0;
        ena  = 1'b1;
        duty = 4'd9;

        // Reset held for two clocks with ena and duty active.
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 9);
            check("reset_out",  int'(out),         0);
            check("reset_done", int'(period_done), 0);
        end

        // First period after reset is low; duty 5 is captured at edge 15.
        run(14, 5, 1'b0, hi, dn);
        check("first_period_hi",   hi, 0);
        check("first_period_done", dn, 0);
        run(1, 5, 1'b0, hi, dn);
        check("wrap15_done", dn, 1);
        check("wrap15_out",  hi, 1);
        run(P, 5, 1'b0, hi, dn);
        check("steady5_hi",   hi, 5);
        check("steady5_done", dn, 1);
        run(P, 5, 1'b0, hi, dn);
        check("steady5_repeat_hi", hi, 5);

        // duty = 0 extreme.
        run(P, 0, 1'b0, hi, dn);
        check("load0_hi", hi, 4);
        run(3 * P, 0, 1'b0, hi, dn);
        check("duty0_hi",   hi, 0);
        check("duty0_done", dn, 3);

        // duty = 15 extreme.
        run(P, 15, 1'b0, hi, dn);
        check("load15_hi", hi, 1);
        run(2 * P, 15, 1'b0, hi, dn);
        check("duty15_hi",   hi, 2 * P);
        check("duty15_done", dn, 2);

        // Mid-period change: 5 loaded, switched to 12 at count 3.
        run(P, 5, 1'b0, hi, dn);
        check("load5_hi", hi, P);
        run(3, 5, 1'b0, hi, dn);
        run(12, 12, 1'b0, hi2, dn2);
        check("midchange_cur_hi", 1 + hi + hi2 - 1, 5);
        check("midchange_tail_hi", hi2, 2);
        // Next period at 12, with a one-cycle glitch to 0 off the wrap edge.
        run(5, 12, 1'b0, hi, dn);
        run(1, 0, 1'b0, hi2, dn2);
        run(9, 12, 1'b0, hi3, dn3);
        check("duty12_hi",   hi + hi2 + hi3, 12);
        check("duty12_done", dn + dn2 + dn3, 1);

        // Gated ticks: one normal period to load 5, then ena toggling.
        run(P, 5, 1'b0, hi, dn);
        check("load5b_hi", hi, 12);
        run(2 * P, 5, 1'b1, hi, dn);
        check("gated_hi",   hi, 10);
        check("gated_done", dn, 1);

        // Reset mid-period at count 7 with duty 10.
        run(P, 10, 1'b0, hi, dn);
        check("load10_hi", hi, 5);
        run(7, 10, 1'b0, hi, dn);
        check("pre_reset_hi",  hi, 7);
        check("pre_reset_out", int'(out), 1);
        step(1'b0, 1'b1, 10);
        check("midreset_out",  int'(out),         0);
        check("midreset_done", int'(period_done), 0);
        run(P, 10, 1'b0, hi, dn);
        check("post_reset_hi",   hi, 1);
        check("post_reset_done", dn, 1);
        run(P, 10, 1'b0, hi, dn);
        check("post_reset_duty10_hi", hi, 10);

        // Randomized traffic checked only by the model.
        for (int i = 0; i < 1500; i++) begin
            int d;
            case ($urandom_range(0, 5))
                0:       d = 0;
                1:       d = P;
                default: d = $urandom_range(0, P);
            endcase
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
